// File: rtl/muldiv_if.sv
// Handshake bundle between the execute-stage controller and muldiv_unit.
// Carries the divzero flag only when MULDIV_DIVZERO_EN is defined.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_EN
  logic             divzero;

  modport master (
    output start, op, a, b, mthi, mtlo, wd,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wd,
    output busy, done, hi, lo, divzero
  );
`else
  modport master (
    output start, op, a, b, mthi, mtlo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wd,
    output busy, done, hi, lo
  );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply, restoring divide.
// MULDIV_DIVZERO_EN: divide-by-zero finishes at E1 with divzero=1 and HI/LO untouched.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
`ifdef MULDIV_DIVZERO_EN
  logic               dz;
  logic               divzero_r;
`endif

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH:0]   acc_next;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    sign_a = ~bus.op[0] & bus.a[WIDTH-1];
    sign_b = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a  = sign_a ? -bus.a : bus.a;
    abs_b  = sign_b ? -bus.b : bus.b;
  end

  // The low half holds the multiplier (shifted out) or the dividend (quotient shifted in).
  always_comb begin
    mul_sum = acc[2*WIDTH:WIDTH] + {1'b0, operand};
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, operand};
    if (is_div) begin
      acc_next = trial[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
    end
  end

  // A product is negated as one double-width value; quotient and remainder separately.
  always_comb begin
    if (is_div) begin
      result = {neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0]};
    end else begin
      result = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz        <= 1'b0;
      divzero_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      divzero_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.mthi) hi_r <= bus.wd;
          if (bus.mtlo) lo_r <= bus.wd;
          if (bus.start) begin
            is_div  <= bus.op[1];
            operand <= abs_b;
            acc     <= {{(WIDTH+1){1'b0}}, abs_a};
            // Divide-by-zero keeps an all-ones quotient, so its sign is never applied.
            neg_lo  <= (sign_a ^ sign_b) & (~bus.op[1] | (|bus.b));
            neg_hi  <= sign_a;
`ifdef MULDIV_DIVZERO_EN
            dz      <= bus.op[1] & ~(|bus.b);
`endif
            count   <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
`ifdef MULDIV_DIVZERO_EN
          if (dz) begin
            done_r    <= 1'b1;
            divzero_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else begin
`else
          begin
`endif
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          {hi_r, lo_r} <= result;
          busy_r       <= 1'b0;
          done_r       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
`ifdef MULDIV_DIVZERO_EN
  assign bus.divzero = divzero_r;
`endif
endmodule
